addr_cmd_dly_seq: RTL and testbench
===================================

# addr_cmd_dly_seq

Fabric-side sequencer directly upstream of the DDR3 address/command lane controller. Accepts tap-move or tap-load requests from the training/calibration logic and drives the lane controller's dynamic delay-line port (`DELAY_LINE_SEL`/`LOAD`/`DIRECTION`/`MOVE`) and `HS_IO_CLK_PAUSE` with the required pause bracketing and inter-step spacing. Tracks the current TX delay tap and reports out-of-range events.

## Interface

**Parameters**
- `PAUSE_SETUP`, default 4: cycles `HS_IO_CLK_PAUSE` is held before the first delay-line action and after the last one. Must be ≥1.
- `MOVE_GAP`, default 3: idle cycles after each `DELAY_LINE_MOVE` pulse. Must be ≥1.

**Ports**
- `FAB_CLK` in, 1: the single clock; all logic is on its rising edge.
- `RESET` in, 1: synchronous, active-high.
- `REQ_VALID` in, 1: request present.
- `REQ_READY` out, 1: high only in IDLE.
- `REQ_OP` in, 1: 0 = move, 1 = load (return to tap 0).
- `REQ_DIR` in, 1: move direction; 1 = increment.
- `REQ_TAPS` in, 8: number of taps to move. Ignored for load.
- `DONE` out, 1: one-cycle completion pulse.
- `ERR` out, 1: sticky out-of-range flag. Cleared on the next accepted request.
- `TAP_COUNT` out, 8: tracked tap position.
- `DELAY_LINE_SEL` out, 1: to the lane controller.
- `DELAY_LINE_LOAD` out, 1: to the lane controller.
- `DELAY_LINE_DIRECTION` out, 1: to the lane controller.
- `DELAY_LINE_MOVE` out, 1: to the lane controller.
- `HS_IO_CLK_PAUSE` out, 1: to the lane controller.
- `TX_DELAY_LINE_OUT_OF_RANGE` in, 1: from the lane controller.

## Operation

- **Outputs:** all registered. Reset values: `REQ_READY`=1, `TAP_COUNT`=0, all other outputs 0.
- **Accept:** a request is accepted when `REQ_VALID && REQ_READY`. The op, direction and taps are latched, `ERR` is cleared, and `REQ_READY` drops the following cycle.
- **FSM states:**
  - IDLE → PAUSE on accept.
    - Exception: a move with `REQ_TAPS`=0 goes straight to DONE with no pause.
  - PAUSE: `HS_IO_CLK_PAUSE`=1, `DELAY_LINE_SEL`=1, `DELAY_LINE_DIRECTION`=latched dir. Lasts `PAUSE_SETUP` cycles, then → STEP (move) or LOAD (load).
  - LOAD: `DELAY_LINE_LOAD`=1 for 1 cycle, `TAP_COUNT`←0, → RESUME.
  - STEP: `DELAY_LINE_MOVE`=1 for 1 cycle. Remaining-tap counter decrements. `TAP_COUNT` ±1, saturating at 0 and 255. → GAP.
  - GAP: `MOVE_GAP` cycles. On the last cycle, `TX_DELAY_LINE_OUT_OF_RANGE` is sampled:
    - If set → `ERR`=1, remaining taps discarded, → RESUME.
    - Else → STEP if taps remain, otherwise RESUME.
  - RESUME: `HS_IO_CLK_PAUSE`=1, `DELAY_LINE_SEL`=1, held for `PAUSE_SETUP` cycles, → DONE.
  - DONE: `DONE`=1, `HS_IO_CLK_PAUSE`=0, `DELAY_LINE_SEL`=0, → IDLE.
- **Pause bracketing:** `HS_IO_CLK_PAUSE` stays high continuously from PAUSE entry through the end of RESUME. `MOVE` and `LOAD` are never asserted while pause is low.
- **Saturation:** when `TAP_COUNT` is saturated, the move pulse is still issued; only the count holds.
- **`REQ_VALID` while busy:** ignored, with no queueing.
- **Reset mid-operation:** all outputs return to their reset values on the next edge, including `HS_IO_CLK_PAUSE`=0.

## Timing

Let the accept edge be at cycle T.

- **Move of N ≥ 1 taps:**
  - PAUSE entered at T+1.
  - First `MOVE` pulse at T+1+`PAUSE_SETUP`.
  - Move pulses spaced 1+`MOVE_GAP` cycles apart.
  - `DONE` at T+1+2·`PAUSE_SETUP`+N·(1+`MOVE_GAP`).
  - `REQ_READY` high one cycle after `DONE`.
- **Load:** `LOAD` pulse at T+1+`PAUSE_SETUP`; `DONE` at T+2+2·`PAUSE_SETUP`.
- **Zero-tap move:** `DONE` at T+1; no pause is asserted.
- **`TAP_COUNT`:** updates on the edge ending the STEP or LOAD cycle.
- **`ERR`:** rises on the edge ending the GAP cycle in which out-of-range was sampled.

## Configuration

- **`ADDR_CMD_DLY_OOR_ABORT_EN` defined:** out-of-range handling as described above (sets `ERR`, aborts the remaining taps).
- **Not defined:** `TX_DELAY_LINE_OUT_OF_RANGE` is ignored. All N taps are always issued and `ERR` is tied to 0. Timing is otherwise identical.

## Test plan

Default parameters (`PAUSE_SETUP`=4, `MOVE_GAP`=3) unless stated.

- **Reset values:** `RESET` for 2 cycles → `REQ_READY`=1, `TAP_COUNT`=0, all delay-line outputs and `HS_IO_CLK_PAUSE`=0.
- **Move up:** 3 taps with `REQ_DIR`=1, accepted at cycle 10 → `MOVE` pulses at 15, 19, 23; `DONE` at 31; `TAP_COUNT`=3; pause high on cycles 11–30.
- **Load after moves:** load issued with `TAP_COUNT`=3 → `LOAD` pulse at T+5, `DONE` at T+10, `TAP_COUNT`=0. Then a 1-tap down move → `TAP_COUNT` stays 0 (saturation) and the pulse is still issued.
- **Out-of-range abort (macro defined):** 5-tap move with out-of-range forced high from the second GAP → exactly 2 `MOVE` pulses, `ERR`=1, `DONE` at T+17. The next accepted request clears `ERR`.
- **Zero taps and reset mid-move:**
  - `REQ_TAPS`=0 → `DONE` at T+1, no pause asserted.
  - `RESET` asserted during GAP of a 4-tap move → pause=0 and ready=1 on the next edge, `TAP_COUNT`=0.

Source files
------------

// File: rtl/addr_cmd_dly_seq.sv
// Delay-line tap sequencer for the DDR3 address/command lane: pause-bracketed tap moves/loads.
// Optional feature macro: ADDR_CMD_DLY_OOR_ABORT_EN (out-of-range abort and sticky ERR).
module addr_cmd_dly_seq #(
    parameter int unsigned PAUSE_SETUP = 4,
    parameter int unsigned MOVE_GAP    = 3
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_OP,
    input  logic       REQ_DIR,
    input  logic [7:0] REQ_TAPS,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] TAP_COUNT,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_MOVE,
    output logic       HS_IO_CLK_PAUSE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned TW      = 8;
    localparam int unsigned CNT_MAX = (PAUSE_SETUP > MOVE_GAP) ? PAUSE_SETUP : MOVE_GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [TW-1:0] TAP_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_LOAD, S_STEP, S_GAP, S_RESUME, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   taps_q;
    logic            op_q, dir_q;
    logic            accept_c, oor_c;
    logic            ready_d, pause_d, load_d, move_d, done_d, dir_d;

    assign accept_c = REQ_VALID && (state_q == S_IDLE);

`ifdef ADDR_CMD_DLY_OOR_ABORT_EN
    assign oor_c = TX_DELAY_LINE_OUT_OF_RANGE;
`else
    logic unused_oor;
    assign unused_oor = TX_DELAY_LINE_OUT_OF_RANGE;
    assign oor_c      = 1'b0;
`endif

    // State register, request latches, tap tracking and registered outputs
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q              <= S_IDLE;
            cnt_q                <= '0;
            taps_q               <= '0;
            op_q                 <= 1'b0;
            dir_q                <= 1'b0;
            ERR                  <= 1'b0;
            TAP_COUNT            <= '0;
            REQ_READY            <= 1'b1;
            DONE                 <= 1'b0;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= (state_d == S_GAP) ? CW'(MOVE_GAP - 1) : CW'(PAUSE_SETUP - 1);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (accept_c) begin
                op_q   <= REQ_OP;
                dir_q  <= REQ_DIR;
                taps_q <= REQ_TAPS;
                ERR    <= 1'b0;
            end

            if (state_q == S_STEP) begin
                taps_q <= taps_q - 1'b1;
                if (dir_q) begin
                    TAP_COUNT <= (TAP_COUNT == TAP_MAX) ? TAP_COUNT : TAP_COUNT + 1'b1;
                end else begin
                    TAP_COUNT <= (TAP_COUNT == '0) ? TAP_COUNT : TAP_COUNT - 1'b1;
                end
            end

            if (state_q == S_LOAD) begin
                TAP_COUNT <= '0;
            end

            // Out-of-range seen on the last gap cycle aborts the rest of the move
            if ((state_q == S_GAP) && (cnt_q == '0) && oor_c) begin
                ERR    <= 1'b1;
                taps_q <= '0;
            end

            REQ_READY            <= ready_d;
            DONE                 <= done_d;
            DELAY_LINE_SEL       <= pause_d;
            DELAY_LINE_LOAD      <= load_d;
            DELAY_LINE_DIRECTION <= dir_d;
            DELAY_LINE_MOVE      <= move_d;
            HS_IO_CLK_PAUSE      <= pause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    state_d = (!REQ_OP && (REQ_TAPS == '0)) ? S_DONE : S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cnt_q == '0) state_d = op_q ? S_LOAD : S_STEP;
            end
            S_LOAD:  state_d = S_RESUME;
            S_STEP:  state_d = S_GAP;
            S_GAP: begin
                if (cnt_q == '0) state_d = (oor_c || (taps_q == '0)) ? S_RESUME : S_STEP;
            end
            S_RESUME: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs track the state register
    always_comb begin
        ready_d = (state_d == S_IDLE);
        pause_d = (state_d == S_PAUSE) || (state_d == S_LOAD) || (state_d == S_STEP) ||
                  (state_d == S_GAP) || (state_d == S_RESUME);
        load_d  = (state_d == S_LOAD);
        move_d  = (state_d == S_STEP);
        done_d  = (state_d == S_DONE);
        dir_d   = 1'b0;
        if (pause_d) begin
            dir_d = (state_q == S_IDLE) ? REQ_DIR : dir_q;
        end
    end

endmodule

// File: tb/tb_addr_cmd_dly_seq.sv
// Self-checking bench for addr_cmd_dly_seq: directed and randomized requests vs. a schedule model.
module tb_addr_cmd_dly_seq;

    localparam int PS = 4;
    localparam int GP = 3;
`ifdef ADDR_CMD_DLY_OOR_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_op = 1'b0;
    logic       req_dir = 1'b0;
    logic [7:0] req_taps = '0;
    logic       done, err;
    logic [7:0] tap_count;
    logic       dl_sel, dl_load, dl_dir, dl_move, pause;
    logic       oor = 1'b0;

    int tests = 0;
    int fails = 0;
    int model_tap = 0;

    addr_cmd_dly_seq #(.PAUSE_SETUP(PS), .MOVE_GAP(GP)) dut (
        .FAB_CLK(clk), .RESET(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_OP(req_op), .REQ_DIR(req_dir), .REQ_TAPS(req_taps),
        .DONE(done), .ERR(err), .TAP_COUNT(tap_count),
        .DELAY_LINE_SEL(dl_sel), .DELAY_LINE_LOAD(dl_load),
        .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_MOVE(dl_move),
        .HS_IO_CLK_PAUSE(pause), .TX_DELAY_LINE_OUT_OF_RANGE(oor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check every cycle against the arithmetic schedule.
    // g: index of the first gap during which out-of-range is held high (0 = never).
    task automatic run_req(input bit op, input bit dir, input int taps, input int g, input bit noise);
        int first, n_eff, end_k, start, mb, tap_e;
        bit err_flag, busy, pause_e, move_e;
        first = 1 + PS;
        start = model_tap;
        err_flag = 1'b0;
        n_eff = 0;
        busy = op || (taps != 0);
        if (op) begin
            end_k = 2 + 2 * PS;
        end else if (taps == 0) begin
            end_k = 1;
        end else begin
            err_flag = ABORT_EN && (g > 0) && (g <= taps);
            n_eff = err_flag ? g : taps;
            end_k = 1 + 2 * PS + n_eff * (1 + GP);
        end

        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_dir   = dir;
        req_taps  = 8'(taps);
        oor       = 1'b0;
        step();
        req_valid = 1'b0;

        for (int k = 1; k <= end_k; k++) begin
            pause_e = busy && (k < end_k);
            move_e  = !op && (taps != 0) && (k >= first) && (((k - first) % (1 + GP)) == 0) &&
                      (((k - first) / (1 + GP)) < n_eff);
            if (op) begin
                tap_e = (k > first) ? 0 : start;
            end else begin
                mb = (k <= first) ? 0 : ((k - first - 1) / (1 + GP) + 1);
                if (mb > n_eff) mb = n_eff;
                tap_e = dir ? ((start + mb > 255) ? 255 : start + mb)
                            : ((start - mb < 0) ? 0 : start - mb);
            end
            chk("pause", pause, pause_e);
            chk("sel", dl_sel, pause_e);
            chk("move", dl_move, move_e);
            chk("load", dl_load, op && (k == first));
            chk("done", done, k == end_k);
            chk("ready_busy", req_ready, 0);
            chk("tap", tap_count, tap_e);
            chk("err", err, err_flag && (k >= end_k - PS));
            if (pause_e) chk("direction", dl_dir, dir);

            oor = (g > 0) && (k >= first + (g - 1) * (1 + GP));
            if (noise && (k < end_k)) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 1'($urandom_range(0, 1));
                req_dir   = 1'($urandom_range(0, 1));
                req_taps  = 8'($urandom_range(0, 255));
            end else begin
                req_valid = 1'b0;
            end
            step();
        end

        oor = 1'b0;
        model_tap = op ? 0 : ((taps == 0) ? start : tap_e);
        if (!op && taps != 0) begin
            model_tap = dir ? ((start + n_eff > 255) ? 255 : start + n_eff)
                            : ((start - n_eff < 0) ? 0 : start - n_eff);
        end
        chk("ready_after_done", req_ready, 1);
        chk("pause_after_done", pause, 0);
        chk("done_after", done, 0);
        chk("tap_final", tap_count, model_tap);
        chk("err_final", err, err_flag);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_tap", tap_count, 0);
        chk("rst_pause", pause, 0);
        chk("rst_sel", dl_sel, 0);
        chk("rst_load", dl_load, 0);
        chk("rst_move", dl_move, 0);
        chk("rst_dir", dl_dir, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (3) step();

        run_req(1'b0, 1'b1, 3, 0, 1'b0);
        run_req(1'b1, 1'b0, 7, 0, 1'b0);
        run_req(1'b0, 1'b0, 1, 0, 1'b0);
        run_req(1'b0, 1'b1, 5, 2, 1'b0);
        run_req(1'b0, 1'b1, 0, 0, 1'b0);
        run_req(1'b0, 1'b1, 255, 0, 1'b0);
        run_req(1'b0, 1'b1, 2, 0, 1'b0);
        run_req(1'b0, 1'b0, 4, 1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_req(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'b1);
        end

        // Reset during the first gap of a 4-tap move
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_dir   = 1'b1;
        req_taps  = 8'd4;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        chk("mid_pause_before_rst", pause, 1);
        rst = 1'b1;
        step();
        chk("midrst_pause", pause, 0);
        chk("midrst_sel", dl_sel, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_tap", tap_count, 0);
        chk("midrst_move", dl_move, 0);
        chk("midrst_done", done, 0);
        rst = 1'b0;
        model_tap = 0;
        step();
        run_req(1'b0, 1'b1, 2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
